// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: master-port request/response and downstream memory signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int GRANT_W   = 1
);
  logic [NUM_PORTS-1:0]            port_ren;
  logic [NUM_PORTS-1:0]            port_wen;
  logic [NUM_PORTS*ADDR_W-1:0]     port_addr;
  logic [NUM_PORTS*DATA_W-1:0]     port_wdata;
  logic [NUM_PORTS*(DATA_W/8)-1:0] port_bsel;
  logic [NUM_PORTS*DATA_W-1:0]     port_rdata;
  logic [NUM_PORTS-1:0]            port_ready;
  logic [NUM_PORTS-1:0]            port_err;
  logic                            mem_req;
  logic                            mem_wen;
  logic [ADDR_W-1:0]               mem_addr;
  logic [DATA_W-1:0]               mem_wdata;
  logic [DATA_W/8-1:0]             mem_bsel;
  logic [DATA_W-1:0]               mem_rdata;
  logic                            mem_ack;
  logic [GRANT_W-1:0]              grant_id;
  modport slave (
    input  port_ren, port_wen, port_addr, port_wdata, port_bsel, mem_rdata, mem_ack,
    output port_rdata, port_ready, port_err, mem_req, mem_wen, mem_addr, mem_wdata, mem_bsel, grant_id
  );
  modport master (
    output port_ren, port_wen, port_addr, port_wdata, port_bsel, mem_rdata, mem_ack,
    input  port_rdata, port_ready, port_err, mem_req, mem_wen, mem_addr, mem_wdata, mem_bsel, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-port arbiter onto one req/ack memory port, one transaction in flight.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with a port_err pulse.
module mem_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int GRANT_W        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DATA_W / 8;
  if (NUM_PORTS < 1 || NUM_PORTS > 8 || DATA_W % 8 != 0 || GRANT_W < 1 ||
      GRANT_W < $clog2(NUM_PORTS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_port_arbiter: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                      state_q, state_d;
  logic [GRANT_W-1:0]          grant_q, grant_d, last_q, last_d, win;
  logic                        mem_req_q, mem_req_d, mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]               mem_bsel_q, mem_bsel_d;
  logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]        req, onehot;
  logic                        timeout;
  assign req    = bus.port_ren | bus.port_wen;
  assign onehot = NUM_PORTS'(1) << grant_q;
  // Descending scan: the last hit is the nearest port after last_q, last_q itself ranks lowest.
  always_comb begin
    win = last_q;
    for (int i = NUM_PORTS; i >= 1; i--)
      if (req[(int'(last_q) + i) % NUM_PORTS]) win = GRANT_W'((int'(last_q) + i) % NUM_PORTS);
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = TIMEOUT_CYCLES > 255 ? 16 : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign timeout = state_q == BUSY && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    cnt_q <= (reset || state_q != BUSY) ? '0 : cnt_q + 1'b1;
    err_q <= reset ? 1'b0 : state_q == BUSY ? timeout && !bus.mem_ack : err_q;
  end
  assign bus.port_err = (state_q == RESP && err_q) ? onehot : '0;
`else
  assign timeout      = 1'b0;
  assign bus.port_err = '0;
`endif
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bsel_d  = mem_bsel_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d     = BUSY;
        grant_d     = win;
        mem_req_d   = 1'b1;
        mem_wen_d   = bus.port_wen[int'(win)];
        mem_addr_d  = bus.port_addr[int'(win)*ADDR_W +: ADDR_W];
        mem_wdata_d = bus.port_wdata[int'(win)*DATA_W +: DATA_W];
        mem_bsel_d  = bus.port_bsel[int'(win)*BW +: BW];
      end
      BUSY: if (bus.mem_ack || timeout) begin
        state_d   = RESP;
        mem_req_d = 1'b0;
        rdata_d[int'(grant_q)*DATA_W +: DATA_W] = (bus.mem_ack && !mem_wen_q) ? bus.mem_rdata : '0;
      end
      RESP: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GRANT_W'(NUM_PORTS - 1);
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bsel_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bsel_q  <= mem_bsel_d;
      rdata_q     <= rdata_d;
    end
  end
  assign bus.port_ready = state_q == RESP ? onehot : '0;
  assign bus.port_rdata = rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_bsel   = mem_bsel_q;
  assign bus.grant_id   = grant_q;
endmodule
